// File: rtl/verificacao_paridade_pkg.sv
// Shared types and the parity rule for the serial parity checker.
package verificacao_paridade_pkg;

  typedef enum logic {
    OCIOSO    = 1'b0,
    RECEBENDO = 1'b1
  } estado_t;

  // Callers zero-extend their data to this width; extra zeros do not change the XOR.
  localparam int LARGURA_MAX = 32;

  function automatic logic paridade_ok_f(
    input logic [LARGURA_MAX-1:0] data,
    input logic                   par,
    input logic                   modo
  );
    return ~(^data ^ par ^ modo);
  endfunction

endpackage

// File: rtl/verificador_paridade_serial_contador.sv
// Saturating up-counter with a clear input that has priority over increment.
module contador_saturado #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         limpa,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (limpa) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/verificador_paridade_serial.sv
// Serial parity checker: assembles MSB-first frames (data then parity bit), checks them,
// and hands each result to a one-entry valid/ready buffer.
module verificador_paridade_serial
  import verificacao_paridade_pkg::*;
#(
  parameter int LARGURA_DADO = 5,
  parameter int CONTADOR_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  input  logic                    inicio,
  input  logic                    modo_impar,
  input  logic                    limpa_cont,
  output logic [LARGURA_DADO-1:0] dado_out,
  output logic                    paridade_ok,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    descarte,
  output logic [CONTADOR_W-1:0]   erro_cont
);

  localparam int BITS_QUADRO = LARGURA_DADO + 1;
  localparam int CNT_W       = $clog2(BITS_QUADRO + 1);

  estado_t                 state_reg, state_next;
  logic [LARGURA_DADO-1:0] shift_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    modo_reg;
  logic                    ultimo_bit;
  logic                    frame_done;
  logic                    ok_now;
  logic                    pop;
  logic                    carrega;

  // The data bits are all in shift_reg when the parity bit arrives, so the check is combinational.
  assign ok_now  = paridade_ok_f(LARGURA_MAX'(shift_reg), bit_in, modo_reg);
  assign pop     = out_valid && out_ready;
  assign carrega = frame_done && (!out_valid || pop);

  always_comb begin
    state_next = state_reg;
    frame_done = 1'b0;
    ultimo_bit = (cnt_reg == CNT_W'(LARGURA_DADO));
    case (state_reg)
      OCIOSO: begin
        if (bit_valid && inicio) state_next = RECEBENDO;
      end
      RECEBENDO: begin
        if (bit_valid && !inicio && ultimo_bit) begin
          frame_done = 1'b1;
          state_next = OCIOSO;
        end
      end
      default: state_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= OCIOSO;
      shift_reg <= '0;
      cnt_reg   <= '0;
      modo_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (bit_valid && inicio) begin
        // A start bit always opens a fresh frame, even mid-frame or on the parity slot.
        shift_reg <= LARGURA_DADO'(bit_in);
        cnt_reg   <= CNT_W'(1);
        modo_reg  <= modo_impar;
      end else if (bit_valid && (state_reg == RECEBENDO)) begin
        if (ultimo_bit) begin
          cnt_reg <= '0;
        end else begin
          shift_reg <= {shift_reg[LARGURA_DADO-2:0], bit_in};
          cnt_reg   <= cnt_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dado_out    <= '0;
      paridade_ok <= 1'b0;
      out_valid   <= 1'b0;
      descarte    <= 1'b0;
    end else begin
      descarte <= frame_done && out_valid && !pop;
      if (carrega) begin
        dado_out    <= shift_reg;
        paridade_ok <= ok_now;
        out_valid   <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Dropped frames still count as errors, so the increment uses frame_done, not carrega.
  contador_saturado #(
    .W(CONTADOR_W)
  ) u_contador_erros (
    .clk  (clk),
    .rst  (rst),
    .inc  (frame_done && !ok_now),
    .limpa(limpa_cont),
    .count(erro_cont)
  );

endmodule

// File: tb/tb_verificador_paridade_serial.sv
// Scoreboard bench: a frame-level reference model feeds an expected-result queue that a
// negedge monitor consumes whenever the DUT presents a result.
module tb_verificador_paridade_serial;

  localparam int LD  = 5;
  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_in;
  logic          bit_valid;
  logic          inicio;
  logic          modo_impar;
  logic          limpa_cont;
  logic          out_ready;
  logic [LD-1:0] dado_out;
  logic          paridade_ok;
  logic          out_valid;
  logic          descarte;
  logic [CW-1:0] erro_cont;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [LD-1:0] dado;
    logic          ok;
  } res_t;

  res_t    exp_q[$];
  bit      m_frame[$];
  bit      m_in;
  bit      m_mode;
  bit      m_occ;
  bit      m_desc;
  int      m_cnt;
  bit      m_done;
  bit      m_ok;
  bit [LD-1:0] m_d;
  int      m_ones;

  always #5 clk = ~clk;

  verificador_paridade_serial #(
    .LARGURA_DADO(LD),
    .CONTADOR_W  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .inicio     (inicio),
    .modo_impar (modo_impar),
    .limpa_cont (limpa_cont),
    .dado_out   (dado_out),
    .paridade_ok(paridade_ok),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .descarte   (descarte),
    .erro_cont  (erro_cont)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames as bit lists, parity as a count of ones.
  always @(posedge clk) begin
    if (rst) begin
      m_frame.delete();
      exp_q.delete();
      m_in   = 1'b0;
      m_mode = 1'b0;
      m_occ  = 1'b0;
      m_desc = 1'b0;
      m_cnt  = 0;
    end else begin
      m_done = 1'b0;
      m_desc = 1'b0;
      m_ok   = 1'b0;
      if (bit_valid) begin
        if (inicio) begin
          m_frame.delete();
          m_frame.push_back(bit_in);
          m_mode = modo_impar;
          m_in   = 1'b1;
        end else if (m_in) begin
          m_frame.push_back(bit_in);
          if (m_frame.size() == LD + 1) begin
            m_done = 1'b1;
            m_in   = 1'b0;
          end
        end
      end
      if (m_occ && out_ready) m_occ = 1'b0;
      if (m_done) begin
        for (int i = 0; i < LD; i++) m_d[LD-1-i] = m_frame[i];
        m_ones = $countones(m_d) + int'(m_frame[LD]);
        m_ok   = ((m_ones % 2) == (m_mode ? 1 : 0));
        if (!m_occ) begin
          exp_q.push_back('{dado: m_d, ok: m_ok});
          m_occ = 1'b1;
        end else begin
          m_desc = 1'b1;
        end
      end
      if (limpa_cont) m_cnt = 0;
      else if (m_done && !m_ok && m_cnt < SAT) m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", out_valid, m_occ);
      check("descarte", descarte, m_desc);
      check("erro_cont", erro_cont, m_cnt);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard: out_valid=1 dado_out=%0h but no result expected at %0t", dado_out, $time);
        end else begin
          check("dado_out", dado_out, exp_q[0].dado);
          check("paridade_ok", paridade_ok, exp_q[0].ok);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b, input logic ini, input logic modo, input int gap, input logic lim);
    bit_valid = 1'b0;
    inicio    = 1'b0;
    repeat (gap) tick();
    bit_in     = b;
    inicio     = ini;
    modo_impar = modo;
    limpa_cont = lim;
    bit_valid  = 1'b1;
    tick();
    bit_valid  = 1'b0;
    inicio     = 1'b0;
    limpa_cont = 1'b0;
  endtask

  task automatic send_frame(input logic [LD-1:0] d, input logic p, input logic modo,
                            input int maxgap, input logic lim_last);
    for (int i = 0; i < LD; i++) send_bit(d[LD-1-i], (i == 0), modo, $urandom_range(0, maxgap), 1'b0);
    send_bit(p, 1'b0, modo, lim_last ? 0 : $urandom_range(0, maxgap), lim_last);
  endtask

  initial begin
    logic [LD-1:0] rd;
    logic          rp;
    logic          rm;
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; inicio = 1'b0;
    modo_impar = 1'b0; limpa_cont = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst    = 1'b0;
    mon_en = 1'b1;
    check("rst_dado_out", dado_out, 0);
    check("rst_paridade_ok", paridade_ok, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_erro_cont", erro_cont, 0);

    send_frame(5'b10110, 1'b1, 1'b0, 0, 1'b0);
    check("even_ok_dado", dado_out, 5'b10110);
    check("even_ok_par", paridade_ok, 1);
    check("even_ok_valid", out_valid, 1);
    check("even_ok_cnt", erro_cont, 0);

    send_frame(5'b10110, 1'b0, 1'b0, 0, 1'b0);
    check("even_bad_par", paridade_ok, 0);
    check("even_bad_cnt", erro_cont, 1);

    send_frame(5'b10110, 1'b0, 1'b1, 0, 1'b0);
    check("odd_ok_par", paridade_ok, 1);
    check("odd_ok_cnt", erro_cont, 1);

    tick();
    out_ready = 1'b0;
    send_frame(5'b01100, 1'b0, 1'b0, 0, 1'b0);
    send_frame(5'b11111, 1'b1, 1'b0, 0, 1'b0);
    check("hold_descarte", descarte, 1);
    check("hold_dado", dado_out, 5'b01100);
    tick();
    check("hold_descarte_end", descarte, 0);
    out_ready = 1'b1;
    tick();
    check("hold_pop_valid", out_valid, 0);

    for (int g = 0; g <= 3; g++) begin
      rd = LD'($urandom); rp = 1'($urandom); rm = 1'($urandom);
      send_bit(1'b1, 1'b1, 1'b0, g, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0, g, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0, g, 1'b0);
      send_frame(rd, rp, rm, g, 1'b0);
      check("restart_dado", dado_out, rd);
    end

    limpa_cont = 1'b1;
    tick();
    limpa_cont = 1'b0;
    repeat (5) send_frame(5'b10110, 1'b0, 1'b0, 1, 1'b0);
    check("sat_cnt", erro_cont, SAT);
    send_frame(5'b10110, 1'b0, 1'b0, 0, 1'b1);
    check("clear_wins_cnt", erro_cont, 0);

    send_bit(1'b1, 1'b1, 1'b0, 0, 1'b0);
    repeat (3) send_bit(1'b1, 1'b0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_dado", dado_out, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_cnt", erro_cont, 0);
    send_bit(1'b1, 1'b0, 1'b0, 0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0, 0, 1'b0);
    check("midrst_ignored", out_valid, 0);
    send_frame(5'b10011, 1'b1, 1'b0, 0, 1'b0);
    check("midrst_next_dado", dado_out, 5'b10011);
    check("midrst_next_par", paridade_ok, 1);

    for (int i = 0; i < 800; i++) begin
      out_ready  = ($urandom_range(0, 3) != 0);
      bit_valid  = ($urandom_range(0, 2) != 0);
      bit_in     = 1'($urandom);
      inicio     = ($urandom_range(0, 7) == 0);
      modo_impar = 1'($urandom);
      limpa_cont = ($urandom_range(0, 59) == 0);
      tick();
    end
    bit_valid  = 1'b0;
    inicio     = 1'b0;
    limpa_cont = 1'b0;
    out_ready  = 1'b1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
